decimate_stage: RTL and testbench



---
 rtl/decim_pkg.sv | 12 +
 rtl/sample_fifo.sv | 55 +++++
 rtl/decimate_stage.sv | 70 +++++++
 tb/tb_decimate_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/decim_pkg.sv
// Shared sizing helpers for the decimator and its output FIFO.
package decim_pkg;

  function automatic int calc_shift(input int ratio);
    return $clog2(ratio);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small register FIFO, head visible combinationally (0 when empty), one-cycle write.
// Pop wins room for a same-cycle push, so a full FIFO accepts push+pop together.
module sample_fifo
  import decim_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [ptr_w(DEPTH):0]  level
);

  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level == '0);
  assign full     = (level == (PW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their own
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/decimate_stage.sv
// Averages each block of RATIO valid samples into one output; result visible 1 cycle after the last sample.
// Consumer backpressure via ready_in; a result arriving at a full FIFO with no pop is dropped and overflow sticks.
module decimate_stage
  import decim_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RATIO = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   valid_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic                   overflow,
  output logic [ptr_w(DEPTH):0]  level
);

  localparam int SHIFT = calc_shift(RATIO);
  localparam int ACC_W = WIDTH + SHIFT;

  typedef logic [ACC_W-1:0] acc_t;

  acc_t             acc;
  acc_t             sum;
  logic [SHIFT-1:0] phase;
  logic             blk_done;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] result;

  assign sum       = acc + acc_t'(data_in);
  assign blk_done  = valid_in && (phase == SHIFT'(RATIO - 1));
  assign result    = sum[ACC_W-1:SHIFT];
  assign valid_out = !fifo_empty;
  assign pop       = ready_in && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      phase    <= '0;
      overflow <= 1'b0;
    end else begin
      if (valid_in) begin
        phase <= phase + 1'b1;
        acc   <= blk_done ? '0 : sum;
      end
      if (blk_done && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (blk_done),
    .push_data (result),
    .pop       (pop),
    .pop_data  (data_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

endmodule

// File: tb/tb_decimate_stage.sv
// Bench for decimate_stage: explicit vector table, directed corner sequences, random run against a queue model.
module tb_decimate_stage;

  localparam int WIDTH = 16;
  localparam int RATIO = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             valid_in = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             ready_in = 1'b0;
  logic             overflow;
  logic [2:0]       level;

  decimate_stage #(.WIDTH(WIDTH), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .overflow  (overflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: raw samples of the current block, stored results, sticky drop flag
  int m_blk[$];
  int m_q[$];
  bit m_ovf;

  task automatic model_clear();
    m_blk.delete();
    m_q.delete();
    m_ovf = 0;
  endtask

  task automatic model_edge(input bit v, input int d, input bit r);
    bit have_res = 0;
    int res = 0;
    int sum = 0;
    bit was_full = (m_q.size() == DEPTH);
    bit popped = r && (m_q.size() > 0);
    if (v) begin
      m_blk.push_back(d);
      if (m_blk.size() == RATIO) begin
        foreach (m_blk[i]) sum += m_blk[i];
        res = sum / RATIO;
        have_res = 1;
        m_blk.delete();
      end
    end
    if (popped) void'(m_q.pop_front());
    if (have_res) begin
      if (!was_full || popped) m_q.push_back(res);
      else m_ovf = 1;
    end
  endtask

  task automatic model_compare(input string tag);
    chk({tag, ".valid"}, 32'(valid_out), 32'(m_q.size() > 0));
    chk({tag, ".data"}, 32'(data_out), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    chk({tag, ".level"}, 32'(level), 32'(m_q.size()));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  // Inputs change at posedge+1, outputs are sampled at posedge+1 after the edge
  task automatic step(input string tag, input bit v, input int d, input bit r);
    valid_in = v;
    data_in  = WIDTH'(d);
    ready_in = r;
    @(posedge clk);
    model_edge(v, d, r);
    #1;
    model_compare(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    #1;
    chk("rst.valid", 32'(valid_out), 0);
    chk("rst.data", 32'(data_out), 0);
    chk("rst.level", 32'(level), 0);
    chk("rst.ovf", 32'(overflow), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  typedef struct {
    bit         v;
    logic [15:0] d;
    bit         r;
    bit         ev;
    logic [15:0] ed;
    int         el;
    bit         eo;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit v, input logic [15:0] d, input bit r,
                              input bit ev, input logic [15:0] ed, input int el, input bit eo);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.ev = ev; t.ed = ed; t.el = el; t.eo = eo;
    vecs.push_back(t);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Plain averaging, one-cycle output pulse
    add(1, 16'd1, 1, 0, 16'd0, 0, 0);
    add(1, 16'd2, 1, 0, 16'd0, 0, 0);
    add(1, 16'd3, 1, 0, 16'd0, 0, 0);
    add(1, 16'd4, 1, 1, 16'd2, 1, 0);
    add(0, 16'd0, 1, 0, 16'd0, 0, 0);
    add(0, 16'd0, 1, 0, 16'd0, 0, 0);
    // Full-scale samples must not wrap the accumulator
    add(1, 16'hFFFF, 1, 0, 16'd0, 0, 0);
    add(1, 16'hFFFF, 1, 0, 16'd0, 0, 0);
    add(1, 16'hFFFF, 1, 0, 16'd0, 0, 0);
    add(1, 16'hFFFF, 1, 1, 16'hFFFF, 1, 0);
    add(0, 16'd0, 1, 0, 16'd0, 0, 0);
    // Idle gaps inside a block
    add(1, 16'd8, 1, 0, 16'd0, 0, 0);
    add(1, 16'd8, 1, 0, 16'd0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 16'd0, 1, 0, 16'd0, 0, 0);
    add(1, 16'd8, 1, 0, 16'd0, 0, 0);
    add(1, 16'd8, 1, 1, 16'd8, 1, 0);
    add(0, 16'd0, 1, 0, 16'd0, 0, 0);
    // Truncation: (1+1+1+2)>>2 = 1
    add(1, 16'd1, 1, 0, 16'd0, 0, 0);
    add(1, 16'd1, 1, 0, 16'd0, 0, 0);
    add(1, 16'd1, 1, 0, 16'd0, 0, 0);
    add(1, 16'd2, 1, 1, 16'd1, 1, 0);
    add(0, 16'd0, 1, 0, 16'd0, 0, 0);

    do_reset();
    foreach (vecs[i]) begin
      valid_in = vecs[i].v;
      data_in  = vecs[i].d;
      ready_in = vecs[i].r;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.valid", i), 32'(valid_out), 32'(vecs[i].ev));
      chk($sformatf("vec%0d.data", i), 32'(data_out), 32'(vecs[i].ed));
      chk($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].el));
      chk($sformatf("vec%0d.ovf", i), 32'(overflow), 32'(vecs[i].eo));
    end

    // Backpressure: five blocks into a four-deep FIFO, fifth result dropped
    do_reset();
    for (int k = 1; k <= 5; k++)
      for (int s = 0; s < RATIO; s++) step("bp.fill", 1, k, 0);
    chk("bp.level_full", 32'(level), 32'd4);
    chk("bp.head_held", 32'(data_out), 32'd1);
    chk("bp.ovf_set", 32'(overflow), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      chk("bp.drain_order", 32'(data_out), 32'(k));
      step("bp.drain", 0, 0, 1);
    end
    chk("bp.level_empty", 32'(level), 32'd0);
    chk("bp.ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with a pop on the same edge as the fifth push
    do_reset();
    for (int k = 1; k <= 4; k++)
      for (int s = 0; s < RATIO; s++) step("fp.fill", 1, k, 0);
    for (int s = 0; s < RATIO - 1; s++) step("fp.blk5", 1, 5, 0);
    step("fp.pushpop", 1, 5, 1);
    chk("fp.level_kept", 32'(level), 32'd4);
    chk("fp.no_ovf", 32'(overflow), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      chk("fp.drain_order", 32'(data_out), 32'(k));
      step("fp.drain", 0, 0, 1);
    end

    // Reset mid-block with a result already stored
    do_reset();
    for (int s = 0; s < RATIO; s++) step("mr.pre", 1, 100, 0);
    step("mr.part", 1, 100, 0);
    step("mr.part", 1, 100, 0);
    chk("mr.pre_valid", 32'(valid_out), 32'd1);
    do_reset();
    for (int s = 0; s < RATIO; s++) step("mr.post", 1, 4, 1);
    chk("mr.result", 32'(data_out), 32'd4);
    chk("mr.result_valid", 32'(valid_out), 32'd1);
    step("mr.idle", 0, 0, 1);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit v = ($urandom_range(0, 9) < 7);
      bit r = ($urandom_range(0, 9) < ((i / 500) % 2 ? 3 : 7));
      int d = (($urandom_range(0, 7) == 0) ? 16'hFFFF : int'($urandom_range(0, 65535)));
      step("rnd", v, d, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
